dcache_wb_dm: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the pipelined CPU's MEM stage and a multi-cycle backing data memory.
- Accepts one word load/store at a time. Returns a hit in one cycle.
- On a miss, stalls the pipeline through `is_ready`, writes back the dirty victim line, then refills the line.

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_wb_dm_if.sv | 43 ++++
 rtl/dcache_tag_data_array.sv | 53 +++++
 rtl/dcache_wb_dm.sv | 173 +++++++++++++++++
 tb/tb_dcache_wb_dm.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared constants for the direct-mapped write-back data cache: FSM state codes
// and the default address-split widths.
package dcache_pkg;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_LINE_WORDS = 4;
   localparam int DEF_NUM_SETS   = 16;

   localparam int WSEL_W = $clog2(DEF_LINE_WORDS);
   localparam int OFF_W  = WSEL_W + 2;
   localparam int IDX_W  = $clog2(DEF_NUM_SETS);
   localparam int TAG_W  = DEF_ADDR_WIDTH - OFF_W - IDX_W;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE      = 3'd0;
   localparam state_t S_COMPARE   = 3'd1;
   localparam state_t S_WRITEBACK = 3'd2;
   localparam state_t S_ALLOCATE  = 3'd3;
   localparam state_t S_FILL_WAIT = 3'd4;

endpackage

// File: rtl/dcache_wb_dm_if.sv
// CPU-side request/response and backing-memory bus of the data cache.
// The cache uses the slave modport; the CPU/memory side uses master.
interface dcache_wb_dm_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WORDS = 4
);
   logic                     is_input_valid;
   logic [ADDR_WIDTH-1:0]    addr;
   logic                     mem_rw;
   logic [31:0]              din;
   logic                     is_ready;
   logic                     is_output_valid;
   logic [31:0]              dout;
   logic                     is_hit;

   logic                     mem_req_valid;
   logic                     mem_req_ready;
   logic                     mem_req_write;
   logic [ADDR_WIDTH-1:0]    mem_req_addr;
   logic [32*LINE_WORDS-1:0] mem_req_wdata;
   logic                     mem_resp_valid;
   logic [32*LINE_WORDS-1:0] mem_resp_rdata;

   logic [31:0]              hit_count;
   logic [31:0]              miss_count;

   modport slave (
      input  is_input_valid, addr, mem_rw, din,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
      output is_ready, is_output_valid, dout, is_hit,
      output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
      output hit_count, miss_count
   );

   modport master (
      output is_input_valid, addr, mem_rw, din,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata,
      input  is_ready, is_output_valid, dout, is_hit,
      input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
      input  hit_count, miss_count
   );

endinterface

// File: rtl/dcache_tag_data_array.sv
// Per-set valid/dirty/tag/line storage: asynchronous read, single synchronous
// write port, valid/dirty cleared by the asynchronous reset.
module dcache_tag_data_array
   import dcache_pkg::*;
#(
   parameter int NUM_SETS  = DEF_NUM_SETS,
   parameter int SET_IDX_W = $clog2(NUM_SETS),
   parameter int SET_TAG_W = TAG_W,
   parameter int LINE_BITS = 32 * DEF_LINE_WORDS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [SET_IDX_W-1:0] i_idx,
   input  logic                 i_we,
   input  logic                 i_wr_valid,
   input  logic                 i_wr_dirty,
   input  logic [SET_TAG_W-1:0] i_wr_tag,
   input  logic [LINE_BITS-1:0] i_wr_line,
   output logic                 o_valid,
   output logic                 o_dirty,
   output logic [SET_TAG_W-1:0] o_tag,
   output logic [LINE_BITS-1:0] o_line
);

   logic [NUM_SETS-1:0]  r_valid;
   logic [NUM_SETS-1:0]  r_dirty;
   logic [SET_TAG_W-1:0] r_tag  [NUM_SETS];
   logic [LINE_BITS-1:0] r_line [NUM_SETS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_we) begin
         r_valid[i_idx] <= i_wr_valid;
         r_dirty[i_idx] <= i_wr_dirty;
      end
   end

   // Tag and data contents are meaningless until valid is set, so no reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_tag[i_idx]  <= i_wr_tag;
         r_line[i_idx] <= i_wr_line;
      end
   end

   assign o_valid = r_valid[i_idx];
   assign o_dirty = r_dirty[i_idx];
   assign o_tag   = r_tag[i_idx];
   assign o_line  = r_line[i_idx];

endmodule

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache: request FSM, victim
// write-back / line refill sequencing and saturating hit/miss counters.
module dcache_wb_dm
   import dcache_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int NUM_SETS   = DEF_NUM_SETS
) (
   input logic           clk,
   input logic           reset,
   dcache_wb_dm_if.slave bus
);

   localparam int L_WSEL = $clog2(LINE_WORDS);
   localparam int L_OFF  = L_WSEL + 2;
   localparam int L_IDX  = $clog2(NUM_SETS);
   localparam int L_TAG  = ADDR_WIDTH - L_OFF - L_IDX;
   localparam int L_LINE = 32 * LINE_WORDS;

   state_t            r_state;
   logic [L_TAG-1:0]  r_tag;
   logic [L_IDX-1:0]  r_idx;
   logic [L_WSEL-1:0] r_word;
   logic              r_rw;
   logic [31:0]       r_din;
   logic              r_miss;
   logic [31:0]       r_hit_cnt;
   logic [31:0]       r_miss_cnt;

   logic              w_valid;
   logic              w_dirty;
   logic [L_TAG-1:0]  w_tag_q;
   logic [L_LINE-1:0] w_line;
   logic              w_hit;
   logic [31:0]       w_sel_word;
   logic [L_LINE-1:0] w_merged_line;
   logic              w_we;
   logic              w_wr_valid;
   logic              w_wr_dirty;
   logic [L_TAG-1:0]  w_wr_tag;
   logic [L_LINE-1:0] w_wr_line;

   dcache_tag_data_array #(
      .NUM_SETS  (NUM_SETS),
      .SET_IDX_W (L_IDX),
      .SET_TAG_W (L_TAG),
      .LINE_BITS (L_LINE)
   ) u_array (
      .clk        (clk),
      .reset      (reset),
      .i_idx      (r_idx),
      .i_we       (w_we),
      .i_wr_valid (w_wr_valid),
      .i_wr_dirty (w_wr_dirty),
      .i_wr_tag   (w_wr_tag),
      .i_wr_line  (w_wr_line),
      .o_valid    (w_valid),
      .o_dirty    (w_dirty),
      .o_tag      (w_tag_q),
      .o_line     (w_line)
   );

   assign w_hit = (r_state == S_COMPARE) && w_valid && (w_tag_q == r_tag);

   // Word select for loads and the store-merged line share the same decode.
   always_comb begin
      w_sel_word    = '0;
      w_merged_line = w_line;
      for (int w = 0; w < LINE_WORDS; w++) begin
         if (r_word == w[L_WSEL-1:0]) begin
            w_sel_word                = w_line[w*32 +: 32];
            w_merged_line[w*32 +: 32] = r_din;
         end
      end
   end

   always_comb begin
      w_we       = 1'b0;
      w_wr_valid = w_valid;
      w_wr_dirty = w_dirty;
      w_wr_tag   = w_tag_q;
      w_wr_line  = w_line;
      case (r_state)
         S_COMPARE: begin
            if (w_hit && r_rw) begin
               w_we       = 1'b1;
               w_wr_dirty = 1'b1;
               w_wr_line  = w_merged_line;
            end
         end
         S_WRITEBACK: begin
            if (bus.mem_req_ready) begin
               w_we       = 1'b1;
               w_wr_dirty = 1'b0;
            end
         end
         S_FILL_WAIT: begin
            if (bus.mem_resp_valid) begin
               w_we       = 1'b1;
               w_wr_valid = 1'b1;
               w_wr_dirty = 1'b0;
               w_wr_tag   = r_tag;
               w_wr_line  = bus.mem_resp_rdata;
            end
         end
         default: ;
      endcase
   end

   // Completion is only ever signalled from COMPARE, so a refilled request is
   // counted once, as a miss, when its second lookup hits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_tag      <= '0;
         r_idx      <= '0;
         r_word     <= '0;
         r_rw       <= 1'b0;
         r_din      <= '0;
         r_miss     <= 1'b0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.is_input_valid) begin
                  r_tag   <= bus.addr[ADDR_WIDTH-1:L_OFF+L_IDX];
                  r_idx   <= bus.addr[L_OFF+L_IDX-1:L_OFF];
                  r_word  <= bus.addr[L_OFF-1:2];
                  r_rw    <= bus.mem_rw;
                  r_din   <= bus.din;
                  r_miss  <= 1'b0;
                  r_state <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               if (w_hit) begin
                  r_state <= S_IDLE;
                  if (!r_miss) begin
                     if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
                  end else begin
                     if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
                  end
               end else begin
                  r_miss  <= 1'b1;
                  r_state <= (w_valid && w_dirty) ? S_WRITEBACK : S_ALLOCATE;
               end
            end
            S_WRITEBACK: if (bus.mem_req_ready)  r_state <= S_ALLOCATE;
            S_ALLOCATE:  if (bus.mem_req_ready)  r_state <= S_FILL_WAIT;
            S_FILL_WAIT: if (bus.mem_resp_valid) r_state <= S_COMPARE;
            default:     r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.is_ready        = (r_state == S_IDLE);
   assign bus.is_output_valid = w_hit;
   assign bus.is_hit          = w_hit && !r_miss;
   assign bus.dout            = w_hit ? w_sel_word : 32'd0;

   // Request fields derive only from held state, so they stay stable while stalled.
   assign bus.mem_req_valid = (r_state == S_WRITEBACK) || (r_state == S_ALLOCATE);
   assign bus.mem_req_write = (r_state == S_WRITEBACK);
   assign bus.mem_req_addr  = (r_state == S_WRITEBACK) ? {w_tag_q, r_idx, {L_OFF{1'b0}}}
                                                       : {r_tag, r_idx, {L_OFF{1'b0}}};
   assign bus.mem_req_wdata = (r_state == S_WRITEBACK) ? w_line : '0;

   assign bus.hit_count  = r_hit_cnt;
   assign bus.miss_count = r_miss_cnt;

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Directed, table-driven bench for dcache_wb_dm with a 3-cycle backing-memory
// model whose untouched words read as 0x1000_0000 + byte address.
module tb_dcache_wb_dm;

   logic clk;
   logic reset;

   dcache_wb_dm_if #(.ADDR_WIDTH(32), .LINE_WORDS(4)) bus ();

   dcache_wb_dm #(.ADDR_WIDTH(32), .LINE_WORDS(4), .NUM_SETS(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   logic [127:0] memLines [logic [31:0]];
   logic [31:0]  allocQ [$];
   logic [31:0]  wbAddrQ [$];
   logic [127:0] wbDataQ [$];
   int           stallCycles = 0;
   int           respCountdown = 0;
   logic [31:0]  pendAddr = '0;

   function automatic logic [127:0] lineOf(input logic [31:0] a);
      logic [127:0] l;
      if (memLines.exists(a)) return memLines[a];
      for (int k = 0; k < 4; k++) l[k*32 +: 32] = 32'h1000_0000 + a + 32'(4 * k);
      return l;
   endfunction

   // Backing memory: decides ready at each falling edge, answers fills 3 cycles later.
   initial begin
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = '0;
      forever begin
         @(negedge clk);
         bus.mem_resp_valid = 1'b0;
         if (!reset) begin
            respCountdown     = 0;
            bus.mem_req_ready = 1'b1;
         end else begin
            if (respCountdown > 0) begin
               respCountdown--;
               if (respCountdown == 0) begin
                  bus.mem_resp_valid = 1'b1;
                  bus.mem_resp_rdata = lineOf(pendAddr);
               end
            end
            if (bus.mem_req_valid) begin
               if (stallCycles > 0) begin
                  bus.mem_req_ready = 1'b0;
                  stallCycles--;
               end else begin
                  bus.mem_req_ready = 1'b1;
                  if (bus.mem_req_write) begin
                     memLines[bus.mem_req_addr] = bus.mem_req_wdata;
                     wbAddrQ.push_back(bus.mem_req_addr);
                     wbDataQ.push_back(bus.mem_req_wdata);
                  end else begin
                     allocQ.push_back(bus.mem_req_addr);
                     pendAddr      = bus.mem_req_addr;
                     respCountdown = 3;
                  end
               end
            end else begin
               bus.mem_req_ready = 1'b1;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic noteTimeout(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: timed out waiting for the DUT", name);
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic rw, input logic [31:0] d,
                                output logic [31:0] gotDout, output logic gotHit, output int lat);
      int guard;
      gotDout = '0;
      gotHit  = 1'b0;
      lat     = 0;
      guard   = 0;
      while (!bus.is_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.is_ready) noteTimeout("readyWait");
      bus.is_input_valid = 1'b1;
      bus.addr           = a;
      bus.mem_rw         = rw;
      bus.din            = d;
      @(posedge clk);
      #1 bus.is_input_valid = 1'b0;
      lat = 1;
      for (guard = 0; guard < 200; guard++) begin
         @(negedge clk);
         if (bus.is_output_valid) break;
         lat++;
      end
      if (!bus.is_output_valid) noteTimeout("outputWait");
      else begin
         gotDout = bus.dout;
         gotHit  = bus.is_hit;
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        rw;
      logic [31:0] din;
      logic        expHit;
      logic [31:0] expDout;
      int          expHitCnt;
      int          expMissCnt;
      int          expWbs;
   } vec_t;

   vec_t vecs [12];

   initial begin
      logic [31:0]  gotDout;
      logic         gotHit;
      int           lat;
      int           guard;
      logic [127:0] wl;

      vecs[0]  = '{32'h100, 1'b0, 32'h0,         1'b0, 32'h1000_0100, 0, 1, 0};
      vecs[1]  = '{32'h104, 1'b0, 32'h0,         1'b1, 32'h1000_0104, 1, 1, 0};
      vecs[2]  = '{32'h108, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0,         2, 1, 0};
      vecs[3]  = '{32'h200, 1'b0, 32'h0,         1'b0, 32'h1000_0200, 2, 2, 1};
      vecs[4]  = '{32'h100, 1'b0, 32'h0,         1'b0, 32'h1000_0100, 2, 3, 1};
      vecs[5]  = '{32'h108, 1'b0, 32'h0,         1'b1, 32'hDEADBEEF,  3, 3, 1};
      vecs[6]  = '{32'h304, 1'b1, 32'h12345678, 1'b0, 32'h0,         3, 4, 1};
      vecs[7]  = '{32'h304, 1'b0, 32'h0,         1'b1, 32'h12345678,  4, 4, 1};
      vecs[8]  = '{32'h300, 1'b0, 32'h0,         1'b1, 32'h1000_0300, 5, 4, 1};
      vecs[9]  = '{32'h010, 1'b0, 32'h0,         1'b0, 32'h1000_0010, 5, 5, 1};
      vecs[10] = '{32'h100, 1'b0, 32'h0,         1'b0, 32'h1000_0100, 5, 6, 2};
      vecs[11] = '{32'h304, 1'b0, 32'h0,         1'b0, 32'h12345678,  5, 7, 2};

      reset              = 1'b0;
      bus.is_input_valid = 1'b0;
      bus.addr           = '0;
      bus.mem_rw         = 1'b0;
      bus.din            = '0;
      repeat (3) @(negedge clk);
      checkOutput("rstReady",     32'(bus.is_ready),        32'd1);
      checkOutput("rstOutValid",  32'(bus.is_output_valid), 32'd0);
      checkOutput("rstReqValid",  32'(bus.mem_req_valid),   32'd0);
      checkOutput("rstDout",      bus.dout,                 32'd0);
      checkOutput("rstHitCnt",    bus.hit_count,            32'd0);
      checkOutput("rstMissCnt",   bus.miss_count,           32'd0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].addr, vecs[i].rw, vecs[i].din, gotDout, gotHit, lat);
         $display("[TB] vector %0d addr=0x%03h rw=%0d latency=%0d", i, vecs[i].addr, vecs[i].rw, lat);
         checkOutput($sformatf("v%0d.isHit", i), 32'(gotHit), 32'(vecs[i].expHit));
         if (!vecs[i].rw) checkOutput($sformatf("v%0d.dout", i), gotDout, vecs[i].expDout);
         if (vecs[i].expHit) checkOutput($sformatf("v%0d.hitLatency", i), 32'(lat), 32'd1);
         checkOutput($sformatf("v%0d.hitCnt", i),  bus.hit_count,  32'(vecs[i].expHitCnt));
         checkOutput($sformatf("v%0d.missCnt", i), bus.miss_count, 32'(vecs[i].expMissCnt));
         checkOutput($sformatf("v%0d.wbCount", i), 32'(wbAddrQ.size()), 32'(vecs[i].expWbs));
      end

      // Request log: first fill 0x100, second fill 0x200 after the dirty victim left.
      checkOutput("allocCount", 32'(allocQ.size()), 32'd7);
      if (allocQ.size() >= 2) begin
         checkOutput("alloc0Addr", allocQ[0], 32'h100);
         checkOutput("alloc1Addr", allocQ[1], 32'h200);
      end
      if (wbAddrQ.size() >= 2) begin
         checkOutput("wb0Addr", wbAddrQ[0], 32'h100);
         wl = wbDataQ[0];
         checkOutput("wb0Word0", wl[31:0],   32'h1000_0100);
         checkOutput("wb0Word2", wl[95:64],  32'hDEADBEEF);
         checkOutput("wb0Word3", wl[127:96], 32'h1000_010C);
         checkOutput("wb1Addr", wbAddrQ[1], 32'h300);
         wl = wbDataQ[1];
         checkOutput("wb1Word1", wl[63:32],  32'h12345678);
      end

      // Memory holds off ALLOCATE for 5 cycles while the CPU pokes a new request.
      stallCycles = 5;
      bus.is_input_valid = 1'b1;
      bus.addr           = 32'h040;
      bus.mem_rw         = 1'b0;
      @(posedge clk);
      #1 bus.is_input_valid = 1'b0;
      for (guard = 0; guard < 50 && !bus.mem_req_valid; guard++) @(negedge clk);
      if (!bus.mem_req_valid) noteTimeout("stallReqWait");
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("stall%0d.reqValid", i), 32'(bus.mem_req_valid), 32'd1);
         checkOutput($sformatf("stall%0d.reqWrite", i), 32'(bus.mem_req_write), 32'd0);
         checkOutput($sformatf("stall%0d.reqAddr", i),  bus.mem_req_addr,       32'h040);
         checkOutput($sformatf("stall%0d.isReady", i),  32'(bus.is_ready),      32'd0);
         bus.is_input_valid = 1'b1;
         bus.addr           = 32'h500;
         @(negedge clk);
      end
      bus.is_input_valid = 1'b0;
      for (guard = 0; guard < 50 && !bus.is_output_valid; guard++) @(negedge clk);
      if (!bus.is_output_valid) noteTimeout("stallDone");
      else begin
         checkOutput("stallDout",  bus.dout,          32'h1000_0040);
         checkOutput("stallIsHit", 32'(bus.is_hit),   32'd0);
      end
      @(negedge clk);
      checkOutput("stallAllocCount", 32'(allocQ.size()), 32'd8);
      checkOutput("stallMissCnt",    bus.miss_count,     32'd8);
      checkOutput("stallIdleReady",  32'(bus.is_ready),  32'd1);

      // Reset while the fill for 0x0C0 is outstanding.
      bus.is_input_valid = 1'b1;
      bus.addr           = 32'h0C0;
      @(posedge clk);
      #1 bus.is_input_valid = 1'b0;
      for (guard = 0; guard < 50 && !bus.mem_req_valid; guard++) @(negedge clk);
      if (!bus.mem_req_valid) noteTimeout("fillReqWait");
      @(negedge clk);
      checkOutput("fillWaitReqValid", 32'(bus.mem_req_valid), 32'd0);
      #2 reset = 1'b0;
      #1;
      checkOutput("midRstReady",    32'(bus.is_ready),        32'd1);
      checkOutput("midRstReqValid", 32'(bus.mem_req_valid),   32'd0);
      checkOutput("midRstOutValid", 32'(bus.is_output_valid), 32'd0);
      checkOutput("midRstMissCnt",  bus.miss_count,           32'd0);
      checkOutput("midRstHitCnt",   bus.hit_count,            32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      applyStimulus(32'h104, 1'b0, 32'h0, gotDout, gotHit, lat);
      checkOutput("postRstIsHit",   32'(gotHit),    32'd0);
      checkOutput("postRstDout",    gotDout,        32'h1000_0104);
      checkOutput("postRstMissCnt", bus.miss_count, 32'd1);
      checkOutput("postRstHitCnt",  bus.hit_count,  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout: simulation exceeded time limit");
      $fatal(1, "[TB] global timeout");
   end

endmodule
